// File: rtl/tdm_frame_scheduler_if.sv
// Requester fetch bus: per-requester byte/valid toward the scheduler, one-hot ready back.
// Ready is a single-cycle strobe; a requester not valid on its strobe cycle misses its slot.
interface tdm_frame_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/tdm_frame_scheduler.sv
// 32-slot x 8-bit TDM transmit scheduler: fetches each slot byte one cycle ahead and
// shifts it MSB-first; first bit two cycles after en is sampled, no stall on missing data.
module tdm_frame_scheduler #(
  parameter int NREQ  = 4,
  parameter int REQ_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 en,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_slot,
  input  logic [REQ_W:0]       cfg_map,
  tdm_frame_scheduler_if.slave req,
  output logic                 sync,
  output logic                 sdata,
  output logic                 parity,
  output logic [4:0]           timeslot,
  output logic                 busy,
  output logic [7:0]           underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [REQ_W:0] shadow_q [32];
  logic [REQ_W:0] active_q [32];
  logic [7:0]     shift_q;
  logic           parity_q;
  logic           sync_q;
  logic           busy_q;
  logic [4:0]     timeslot_q;
  logic [7:0]     underrun_q;

  logic           frame_end;
  logic           map_copy;
  logic           fetch_on;
  logic [4:0]     fetch_slot;
  logic [REQ_W:0] fetch_entry;
  logic           fetch_hit;
  logic           fetch_valid;
  logic [7:0]     fetch_sel;
  logic [7:0]     fetch_byte;
  logic [NREQ-1:0] fetch_ready;

  assign frame_end = (state_q == RUN) && (bit_cnt_q == 8'hFF);

  // Shadow becomes active on the edge that enters every slot-0 fetch cycle.
  assign map_copy = ((state_q == IDLE) && en) || ((state_q == RUN) && (bit_cnt_q == 8'd254));

  always_comb begin
    fetch_on    = (state_q == PREP) ||
                  ((state_q == RUN) && (bit_cnt_q[2:0] == 3'd7) && ((bit_cnt_q != 8'hFF) || en));
    fetch_slot  = (state_q == RUN) ? (bit_cnt_q[7:3] + 5'd1) : 5'd0;
    fetch_entry = active_q[fetch_slot];
    fetch_hit   = 1'b0;
    fetch_valid = 1'b0;
    fetch_sel   = 8'h00;
    fetch_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (fetch_on && fetch_entry[REQ_W] && (fetch_entry[REQ_W-1:0] == REQ_W'(i))) begin
        fetch_ready[i] = 1'b1;
        fetch_hit      = 1'b1;
        fetch_valid    = req.req_valid[i];
        fetch_sel      = req.req_data[8*i +: 8];
      end
    end
    fetch_byte = fetch_valid ? fetch_sel : 8'h00;
  end

  assign req.req_ready = fetch_ready;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = PREP;
      end
      PREP: begin
        state_d   = RUN;
        bit_cnt_d = 8'd0;
      end
      RUN: begin
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (frame_end && !en) begin
          state_d   = IDLE;
          bit_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 8'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      sync_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeslot_q <= 5'd0;
      underrun_q <= 8'd0;
      for (int i = 0; i < 32; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= (state_d != IDLE);
      sync_q     <= (state_d == RUN) && (bit_cnt_d == 8'hFF);
      timeslot_q <= (state_d == RUN) ? bit_cnt_d[7:3] : 5'd0;

      // The fetched byte lands directly in the shifter at the slot boundary.
      if (fetch_on) begin
        shift_q  <= fetch_byte;
        parity_q <= ^fetch_byte;
      end else if (state_d != RUN) begin
        shift_q  <= 8'h00;
        parity_q <= 1'b0;
      end else begin
        shift_q  <= {shift_q[6:0], 1'b0};
      end

      if (fetch_hit && !fetch_valid && (underrun_q != 8'hFF)) begin
        underrun_q <= underrun_q + 8'd1;
      end

      if (cfg_we) begin
        shadow_q[cfg_slot] <= cfg_map;
      end
      if (map_copy) begin
        for (int i = 0; i < 32; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign sync         = sync_q;
  assign sdata        = shift_q[7];
  assign parity       = parity_q;
  assign timeslot     = timeslot_q;
  assign busy         = busy_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Bench for tdm_frame_scheduler: per-frame expected line values are queued at frame start
// and drained by a mid-cycle monitor; scenario tasks add inline checks at boundaries.
module tb_tdm_frame_scheduler;
  localparam int NREQ  = 4;
  localparam int REQ_W = 3;

  logic           clk      = 1'b0;
  logic           reset_l  = 1'b1;
  logic           en       = 1'b0;
  logic           cfg_we   = 1'b0;
  logic [4:0]     cfg_slot = 5'd0;
  logic [REQ_W:0] cfg_map  = '0;
  logic           sync, sdata, parity, busy;
  logic [4:0]     timeslot;
  logic [7:0]     underrun_cnt;

  tdm_frame_scheduler_if #(.NREQ(NREQ)) req_if ();

  tdm_frame_scheduler #(.NREQ(NREQ), .REQ_W(REQ_W)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .en           (en),
    .cfg_we       (cfg_we),
    .cfg_slot     (cfg_slot),
    .cfg_map      (cfg_map),
    .req          (req_if),
    .sync         (sync),
    .sdata        (sdata),
    .parity       (parity),
    .timeslot     (timeslot),
    .busy         (busy),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            sd;
    logic            par;
    logic            syn;
    logic            bsy;
    logic [4:0]      ts;
    logic [NREQ-1:0] rdy;
  } exp_t;

  exp_t            expq[$];
  exp_t            mon_e, mon_o;
  logic [7:0]      fb [32];
  logic [NREQ-1:0] fr [32];
  int              checks = 0;
  int              errors = 0;
  logic [12:0]     obs;

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      mon_o = {sdata, parity, sync, busy, timeslot, req_if.req_ready};
      checks++;
      if (mon_o !== mon_e) begin
        errors++;
        $display("FAIL frame_cycle %0d: got sd=%b par=%b sync=%b busy=%b ts=%0d rdy=%b, expected sd=%b par=%b sync=%b busy=%b ts=%0d rdy=%b",
                 255 - expq.size(), mon_o.sd, mon_o.par, mon_o.syn, mon_o.bsy, mon_o.ts, mon_o.rdy,
                 mon_e.sd, mon_e.par, mon_e.syn, mon_e.bsy, mon_e.ts, mon_e.rdy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_frame();
    for (int s = 0; s < 32; s++) begin
      fb[s] = 8'h00;
      fr[s] = '0;
    end
  endtask

  // fb[s] is the byte expected in slot s, fr[s] the strobe expected for fetching slot s.
  task automatic push_frame(input logic [NREQ-1:0] rdy255);
    for (int c = 0; c < 256; c++) begin
      exp_t e;
      int   s;
      s     = c / 8;
      e.sd  = fb[s][7 - (c % 8)];
      e.par = ^fb[s];
      e.syn = (c == 255);
      e.bsy = 1'b1;
      e.ts  = 5'(s);
      if (c == 255)        e.rdy = rdy255;
      else if (c % 8 == 7) e.rdy = fr[s + 1];
      else                 e.rdy = '0;
      expq.push_back(e);
    end
  endtask

  task automatic cfg_write(input logic [4:0] slot, input logic [REQ_W:0] map);
    cfg_we   = 1'b1;
    cfg_slot = slot;
    cfg_map  = map;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset_l = 1'b0;
    step_n(2);
    obs = {sdata, parity, sync, busy, timeslot, req_if.req_ready};
    checks++;
    if (obs !== 13'd0 || underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b cnt=%0d, expected all zero", obs, underrun_cnt);
    end
    reset_l = 1'b1;
    step_n(5);
    checks++;
    if (busy !== 1'b0 || req_if.req_ready !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_release: got busy=%b rdy=%b, expected busy=0 rdy=0000", busy, req_if.req_ready);
    end
  endtask

  task automatic test_two_channel();
    cfg_write(5'd0, 4'h8);
    cfg_write(5'd1, 4'h9);
    en = 1'b1;
    step();
    obs = {sdata, parity, sync, busy, timeslot, req_if.req_ready};
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'b0001}) begin
      errors++;
      $display("FAIL prep_cycle: got %b, expected %b", obs, {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'b0001});
    end
    step();
    clear_frame();
    fb[0] = 8'hA5;
    fb[1] = 8'h07;
    fr[1] = 4'b0010;
    push_frame(4'b0001);
    step_n(256);
  endtask

  task automatic test_underrun();
    push_frame(4'b0001);
    cfg_write(5'd2, 4'hB);
    step_n(255);
    fr[2] = 4'b1000;
    push_frame(4'b0001);
    step_n(256);
    checks++;
    if (underrun_cnt !== 8'd1) begin
      errors++;
      $display("FAIL underrun_first: got %0d, expected 1", underrun_cnt);
    end
  endtask

  task automatic test_shadow();
    push_frame(4'b0001);
    step_n(100);
    cfg_write(5'd5, 4'hA);
    step_n(153);
    cfg_write(5'd6, 4'h9);
    step();
    fb[5] = 8'h3C;
    fr[5] = 4'b0100;
    push_frame(4'b0001);
    step_n(256);
    checks++;
    if (underrun_cnt !== 8'd3) begin
      errors++;
      $display("FAIL underrun_per_frame: got %0d, expected 3", underrun_cnt);
    end
  endtask

  task automatic test_stop();
    fb[6] = 8'h07;
    fr[6] = 4'b0010;
    push_frame(4'b0000);
    step_n(50);
    en = 1'b0;
    step_n(206);
    obs = {sdata, parity, sync, busy, timeslot, req_if.req_ready};
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL stop_idle: got %b, expected all zero", obs);
    end
    checks++;
    if (underrun_cnt !== 8'd4) begin
      errors++;
      $display("FAIL underrun_after_stop: got %0d, expected 4", underrun_cnt);
    end
    step_n(3);
    checks++;
    if (busy !== 1'b0 || req_if.req_ready !== 4'b0) begin
      errors++;
      $display("FAIL stays_idle: got busy=%b rdy=%b, expected 0 0000", busy, req_if.req_ready);
    end
  endtask

  task automatic test_restart();
    en = 1'b1;
    step();
    obs = {sdata, parity, sync, busy, timeslot, req_if.req_ready};
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'b0001}) begin
      errors++;
      $display("FAIL restart_prep: got %b, expected %b", obs, {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'b0001});
    end
    step();
    push_frame(4'b0001);
    step_n(256);
    push_frame(4'b0001);
    step_n(256);
    checks++;
    if (underrun_cnt !== 8'd6) begin
      errors++;
      $display("FAIL underrun_after_restart: got %0d, expected 6", underrun_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int s = 3; s < 32; s++) begin
      if (s != 5 && s != 6) cfg_write(5'(s), 4'hB);
    end
    step_n(12 * 256);
    checks++;
    if (underrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL underrun_saturate: got %0d, expected 255", underrun_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    step_n(40);
    reset_l = 1'b0;
    #1;
    obs = {sdata, parity, sync, busy, timeslot, req_if.req_ready};
    checks++;
    if (obs !== 13'd0 || underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_midframe: got %b cnt=%0d, expected all zero", obs, underrun_cnt);
    end
    en = 1'b0;
    step_n(2);
    reset_l = 1'b1;
    step_n(4);
    checks++;
    if (busy !== 1'b0 || sdata !== 1'b0 || sync !== 1'b0) begin
      errors++;
      $display("FAIL no_resume: got busy=%b sdata=%b sync=%b, expected 0 0 0", busy, sdata, sync);
    end
    en = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || req_if.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL maps_cleared_prep: got busy=%b rdy=%b, expected 1 0000", busy, req_if.req_ready);
    end
    en = 1'b0;
    step();
    clear_frame();
    push_frame(4'b0000);
    step_n(256);
    checks++;
    if (busy !== 1'b0 || expq.size() != 0) begin
      errors++;
      $display("FAIL cleared_frame_end: got busy=%b pending=%0d, expected 0 0", busy, expq.size());
    end
  endtask

  initial begin
    req_if.req_valid = 4'b0111;
    req_if.req_data  = {8'hFF, 8'h3C, 8'h07, 8'hA5};
    test_reset();
    test_two_channel();
    test_underrun();
    test_shadow();
    test_stop();
    test_restart();
    test_saturate();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_frame_scheduler.md
# tdm_frame_scheduler

Transmit-side TDM frame scheduler for the channel-transmission link. Shares the 32-slot × 8-bit serial frame among `NREQ` byte requesters according to a programmable slot map. It fetches each slot's byte through a valid/ready handshake and serialises it MSB-first on `sdata`. It also drives the `sync` and per-slot `parity` signals consumed by the receiving end.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `REQ_W`, 3, requester index width (≥ clog2(NREQ))

- `clk` in 1: single clock, all logic on the rising edge
- `reset_l` in 1: asynchronous, active-low reset
- `en` in 1: framing enable, level-sensitive
- `cfg_we` in 1: slot-map write strobe
- `cfg_slot` in 5: slot index to write
- `cfg_map` in REQ_W+1: {mapped, requester id}; mapped=0 marks the slot as idle
- `req_valid` in NREQ: requester has a byte pending
- `req_data` in 8*NREQ: requester i byte on bits [8i+7:8i]
- `req_ready` out NREQ: one-hot fetch strobe
- `sync` out 1: frame marker
- `sdata` out 1: serial data
- `parity` out 1: even parity of the current slot byte
- `timeslot` out 5: slot currently on the line
- `busy` out 1: scheduler is not IDLE
- `underrun_cnt` out 8: saturating count of missed fetches

## Operation
- **Slot maps.** Two 32-entry maps: shadow (written by cfg) and active (used for fetch).
  - Reset clears both maps to unmapped.
  - `cfg_we` writes `shadow[cfg_slot]`; writes are accepted in any state.
  - Shadow is copied to active on the edge entering each slot-0 fetch cycle (IDLE→PREP, and RUN cycle 254→255).
  - If a cfg write coincides with the copy, the write lands in shadow only and takes effect the following frame.
- **FSM states.**
  - IDLE: `en`=1 → PREP.
  - PREP: one cycle; fetches the slot-0 byte; → RUN with `bit_cnt`=0.
  - RUN: `bit_cnt` (8 bits) increments each cycle and wraps 255→0. At `bit_cnt`=255: `en`=1 → stay in RUN (wrap); `en`=0 → IDLE.
- **Fetch cycles.**
  - Slot s+1 is fetched at `bit_cnt`=8s+7, for s = 0..30.
  - Slot 0 is fetched in PREP, or at `bit_cnt`=255 when `en`=1.
  - No fetch occurs at 255 when `en`=0.
- **Fetch rule.** Look up active[next slot].
  - Mapped to requester i: `req_ready[i]`=1 for exactly that cycle. Ready depends only on state, never on `req_valid`.
  - Transfer when `req_valid[i]`=1: `req_data[i]` is loaded into the next-byte register.
  - `req_valid[i]`=0: the next byte is 0x00 and `underrun_cnt` increments, saturating at 255.
  - Unmapped slot: next byte is 0x00, no ready pulse, no underrun.
- **Serialisation.**
  - At each slot boundary the next-byte register moves to the shift register.
  - `sdata` = bit (7 − `bit_cnt`[2:0]) of the slot byte.
  - `parity` = XOR of the slot byte, held constant across the slot's 8 cycles.
- **Frame outputs.**
  - `sync` = 1 exactly when in RUN with `bit_cnt`=255.
  - `timeslot` = `bit_cnt`[7:3] in RUN, 0 otherwise.
- **IDLE and PREP outputs.** `sdata`, `parity`, `sync` and `req_ready` are all 0 (except the PREP fetch strobe).

## Timing
- **Reset values.** All outputs are 0, state is IDLE, `bit_cnt`=0, `underrun_cnt`=0, maps are cleared. Reset takes effect immediately on `reset_l` falling, including mid-frame. No partial frame resumes after release.
- **Start-up latency.** `en` rising in IDLE gives PREP on the next cycle. The MSB of slot 0 appears on `sdata` 2 cycles after `en` was first sampled high.
- **Frame length.** 256 cycles in RUN; back-to-back frames have no gap cycle.
- **Fetch-to-line latency.** A byte fetched at cycle 8s+7 appears on `sdata` from cycle 8(s+1).
- **Stopping.** `en` is sampled only in IDLE and at `bit_cnt`=255. Dropping `en` mid-frame completes the frame, including `sync`, then returns to IDLE.
- **Multiple requesters.** A requester mapped to several slots is strobed once per mapped slot; there is at most one `req_ready` bit per cycle.

## Test plan
- **Reset.** Assert `reset_l`=0 mid-frame → all outputs 0 within the same cycle. After release with `en`=0, `busy` stays 0.
- **Two-channel frame.** Map slot0→req0 and slot1→req1; req0 holds 0xA5 and req1 holds 0x07, both valid; raise `en`.
  - `req_ready[0]` pulses in PREP; `sdata` in cycles 0..7 = 1,0,1,0,0,1,0,1 with `parity`=0.
  - `req_ready[1]` pulses at cycle 7; cycles 8..15 = 0,0,0,0,0,1,1,1 with `parity`=1.
  - `timeslot`=1 during cycles 8..15; `sync`=1 only at cycle 255.
- **Underrun.** Map slot 2→req3 with `req_valid[3]`=0 → slot 2 is sent as 0x00 and `underrun_cnt` is 1. Run 300 frames → the counter saturates at 255.
- **Shadow map.** Write slot5→req2 at cycle 100 → no ready pulse in this frame's slot 5. `req_ready[2]` pulses at cycle 39 of the next frame. A write exactly at cycle 254 takes effect one frame later.
- **Stop.** Drop `en` at cycle 50 → the frame finishes, `sync` is 1 at cycle 255, there is no slot-0 fetch, and the block is IDLE the cycle after.
- **Restart.** Re-raise `en` → PREP, then RUN; wrap 255→0 occurs with no gap when `en` is held.
